// File: rtl/codma_pkg.sv
// codma_pkg: shared widths, descriptor layout and fetch FSM encoding for the DMA slice.
package codma_pkg;
    localparam int ADDR_SIZE  = 32;
    localparam int DATA_SIZE  = 32;
    localparam int DESC_WORDS = 4;
    typedef logic [1:0] state_t;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;
    typedef struct packed {
        logic [DATA_SIZE-1:0] ctrl;
        logic [DATA_SIZE-1:0] src;
        logic [DATA_SIZE-1:0] dst;
        logic [DATA_SIZE-1:0] len;
    } desc_t;
endpackage

// File: rtl/task_fetch_if.sv
// task_fetch_if: burst-read bus between the descriptor fetcher (master) and memory (slave).
interface task_fetch_if #(
    parameter int ADDR_SIZE = codma_pkg::ADDR_SIZE,
    parameter int DATA_SIZE = codma_pkg::DATA_SIZE
);
    logic                 read_request_o;
    logic [ADDR_SIZE-1:0] addr_o;
    logic [3:0]           size_o;
    logic                 grant_i;
    logic [DATA_SIZE-1:0] read_data_i;
    logic                 read_valid_i;
    logic                 error_i;
    modport master (output read_request_o, addr_o, size_o,
                    input  grant_i, read_data_i, read_valid_i, error_i);
    modport slave  (input  read_request_o, addr_o, size_o,
                    output grant_i, read_data_i, read_valid_i, error_i);
endinterface

// File: rtl/task_fetch.sv
// task_fetch: reads a four-word task descriptor over a burst bus and offers it to the move engine.
module task_fetch #(
    parameter int ADDR_SIZE = codma_pkg::ADDR_SIZE,
    parameter int DATA_SIZE = codma_pkg::DATA_SIZE
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 start_i,
    input  logic [ADDR_SIZE-1:0] task_pointer_i,
    output logic                 busy_o,
    task_fetch_if.master         bus,
    output logic                 desc_valid_o,
    input  logic                 desc_ready_i,
    output logic [DATA_SIZE-1:0] desc_ctrl_o,
    output logic [DATA_SIZE-1:0] desc_src_o,
    output logic [DATA_SIZE-1:0] desc_dst_o,
    output logic [DATA_SIZE-1:0] desc_len_o,
    output logic                 fetch_err_o
);
    import codma_pkg::*;
    state_t               state_q, state_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [3:0]           size_q, size_d;
    logic                 req_q, req_d, busy_q, busy_d, valid_q, valid_d, err_q, err_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [DATA_SIZE-1:0] words_q [DESC_WORDS];
    logic [DATA_SIZE-1:0] words_d [DESC_WORDS];
    logic                 abort;
    // a bus error only matters while a burst is outstanding, and beats/grant lose to it
    assign abort = bus.error_i && (state_q == S_REQ || state_q == S_DATA);
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        req_d   = req_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        words_d = words_q;
        err_d   = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            req_d   = 1'b0;
            busy_d  = 1'b0;
            cnt_d   = 2'd0;
            err_d   = 1'b1;
            words_d = '{default: '0};
        end else begin
            case (state_q)
                S_IDLE: if (start_i) begin
                    if (task_pointer_i[1:0] == 2'b00) begin
                        addr_d  = task_pointer_i;
                        size_d  = 4'(DESC_WORDS);
                        req_d   = 1'b1;
                        busy_d  = 1'b1;
                        state_d = S_REQ;
                    end else err_d = 1'b1;
                end
                S_REQ: if (bus.grant_i) begin
                    req_d   = 1'b0;
                    cnt_d   = 2'd0;
                    state_d = S_DATA;
                end
                S_DATA: if (bus.read_valid_i) begin
                    words_d[cnt_q] = bus.read_data_i;
                    cnt_d          = cnt_q + 2'd1;
                    valid_d        = cnt_q == 2'd3;
                    state_d        = cnt_q == 2'd3 ? S_HOLD : S_DATA;
                end
                default: if (desc_ready_i) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 2'd0;
            words_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            words_q <= words_d;
        end
    end
    assign bus.read_request_o = req_q;
    assign bus.addr_o         = addr_q;
    assign bus.size_o         = size_q;
    assign busy_o             = busy_q;
    assign desc_valid_o       = valid_q;
    assign fetch_err_o        = err_q;
    assign desc_ctrl_o        = words_q[0];
    assign desc_src_o         = words_q[1];
    assign desc_dst_o         = words_q[2];
    assign desc_len_o         = words_q[3];
endmodule

// File: tb/tb_task_fetch.sv
// tb_task_fetch: directed scenarios with a descriptor scoreboard checked on every transfer.
module tb_task_fetch;
    logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, ready = 1'b0;
    logic [31:0] ptr = '0;
    logic        busy, valid, err;
    logic [31:0] ctrl, src, dst, len;
    int          checks = 0, failures = 0, xfers = 0, errs = 0;
    logic [127:0] exp_q [$];

    always #5 clk = ~clk;

    task_fetch_if bus_if ();

    task_fetch dut (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .task_pointer_i(ptr),
        .busy_o(busy), .bus(bus_if), .desc_valid_o(valid), .desc_ready_i(ready),
        .desc_ctrl_o(ctrl), .desc_src_o(src), .desc_dst_o(dst), .desc_len_o(len),
        .fetch_err_o(err)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (err) errs++;
        if (valid && ready) begin
            xfers++;
            check("xfer_expected", 128'(exp_q.size() > 0), 128'(1));
            if (exp_q.size() > 0) check("xfer_desc", {ctrl, src, dst, len}, exp_q.pop_front());
        end
    end

    task automatic fetch(input logic [31:0] p, input int gdly, input int gap, input bit junk,
                         input logic [127:0] d);
        logic [31:0] w [4];
        w[0] = d[127:96]; w[1] = d[95:64]; w[2] = d[63:32]; w[3] = d[31:0];
        start = 1'b1; ptr = p;
        tick();
        start = 1'b0;
        check("req_raise", 128'(bus_if.read_request_o), 128'(1));
        check("req_addr", 128'(bus_if.addr_o), 128'(p));
        check("req_size", 128'(bus_if.size_o), 128'(4));
        check("busy_set", 128'(busy), 128'(1));
        repeat (gdly) begin
            bus_if.read_valid_i = junk;
            bus_if.read_data_i  = 32'hDEAD_BEEF;
            tick();
            check("req_hold", 128'({bus_if.read_request_o, bus_if.size_o, bus_if.addr_o}),
                  128'({1'b1, 4'd4, p}));
        end
        bus_if.read_valid_i = 1'b0;
        bus_if.grant_i = 1'b1;
        tick();
        bus_if.grant_i = 1'b0;
        check("req_drop", 128'(bus_if.read_request_o), 128'(0));
        exp_q.push_back(d);
        for (int i = 0; i < 4; i++) begin
            bus_if.read_valid_i = 1'b1;
            bus_if.read_data_i  = w[i];
            tick();
            bus_if.read_valid_i = 1'b0;
            check("desc_valid_timing", 128'(valid), 128'(i == 3));
            if (i < 3) repeat (gap) tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, x0;
        bus_if.grant_i = 1'b0; bus_if.read_valid_i = 1'b0;
        bus_if.read_data_i = '0; bus_if.error_i = 1'b0;
        #3;
        check("reset_ctl", 128'({busy, valid, err, bus_if.read_request_o}), 128'(0));
        check("reset_bus", 128'({bus_if.size_o, bus_if.addr_o}), 128'(0));
        check("reset_desc", {ctrl, src, dst, len}, 128'(0));
        #9 reset_n = 1'b1;
        tick();

        // basic fetch with two-cycle grant delay, consumer always ready
        ready = 1'b1;
        fetch(32'h1000, 2, 0, 1'b0, {32'hA, 32'h2000, 32'h3000, 32'h40});
        tick();
        check("after_xfer", 128'({valid, busy}), 128'(0));
        check("xfers_basic", 128'(xfers), 128'(1));

        // minimum latency path: immediate grant, back-to-back beats, zero length passes
        fetch(32'h5000, 0, 0, 1'b0, {32'h11, 32'h22, 32'h33, 32'h0});
        tick();
        check("latency_done", 128'({valid, busy}), 128'(0));

        // misaligned pointer
        e0 = errs;
        start = 1'b1; ptr = 32'h1002;
        tick();
        start = 1'b0;
        check("mis_err", 128'(err), 128'(1));
        check("mis_noreq", 128'({bus_if.read_request_o, busy}), 128'(0));
        tick();
        check("mis_pulse_end", 128'({err, busy, bus_if.read_request_o}), 128'(0));
        check("mis_pulses", 128'(errs - e0), 128'(1));

        // error while idle is ignored
        bus_if.error_i = 1'b1;
        tick();
        bus_if.error_i = 1'b0;
        check("idle_err_ignored", 128'({err, busy}), 128'(0));

        // bus error after two beats, coinciding with a third beat
        e0 = errs; x0 = xfers;
        start = 1'b1; ptr = 32'h4000;
        tick();
        start = 1'b0;
        bus_if.grant_i = 1'b1;
        tick();
        bus_if.grant_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus_if.read_valid_i = 1'b1; bus_if.read_data_i = 32'hBAD0 + i;
            tick();
        end
        bus_if.error_i = 1'b1; bus_if.read_data_i = 32'hBAD2;
        tick();
        bus_if.error_i = 1'b0; bus_if.read_valid_i = 1'b0;
        check("abort_err", 128'(err), 128'(1));
        check("abort_ctl", 128'({busy, valid, bus_if.read_request_o}), 128'(0));
        tick();
        check("abort_pulse_end", 128'(err), 128'(0));
        check("abort_pulses", 128'(errs - e0), 128'(1));
        check("abort_discard", {ctrl, src, dst, len}, 128'(0));
        check("abort_no_xfer", 128'(xfers - x0), 128'(0));
        fetch(32'h2000, 1, 0, 1'b0, {32'hC1, 32'hC2, 32'hC3, 32'hC4});
        tick();
        check("refetch_done", 128'({valid, busy}), 128'(0));

        // consumer stalls ten cycles, start pulsed while holding
        ready = 1'b0; x0 = xfers;
        fetch(32'h6000, 1, 1, 1'b0, {32'hD1, 32'hD2, 32'hD3, 32'hD4});
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin start = 1'b1; ptr = 32'h7000; end
            tick();
            start = 1'b0;
            check("hold_stable", {ctrl, src, dst, len}, {32'hD1, 32'hD2, 32'hD3, 32'hD4});
            check("hold_ctl", 128'({valid, busy, bus_if.read_request_o}), 128'(3'b110));
        end
        ready = 1'b1;
        tick();
        check("hold_release", 128'({valid, busy, bus_if.read_request_o}), 128'(0));
        tick();
        check("hold_start_ignored", 128'({busy, bus_if.read_request_o}), 128'(0));
        check("hold_one_xfer", 128'(xfers - x0), 128'(1));

        // asynchronous reset during the third beat
        start = 1'b1; ptr = 32'h8000;
        tick();
        start = 1'b0;
        bus_if.grant_i = 1'b1;
        tick();
        bus_if.grant_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus_if.read_valid_i = 1'b1; bus_if.read_data_i = 32'hE0 + i;
            tick();
        end
        bus_if.read_valid_i = 1'b1; bus_if.read_data_i = 32'hE2;
        #2 reset_n = 1'b0;
        #1;
        check("arst_ctl", 128'({busy, valid, err, bus_if.read_request_o}), 128'(0));
        check("arst_bus", 128'({bus_if.size_o, bus_if.addr_o}), 128'(0));
        check("arst_desc", {ctrl, src, dst, len}, 128'(0));
        bus_if.read_valid_i = 1'b0;
        #10 reset_n = 1'b1;
        tick();
        fetch(32'h3000, 0, 2, 1'b0, {32'hF1, 32'hF2, 32'hF3, 32'hF4});
        tick();
        check("post_reset_done", 128'({valid, busy}), 128'(0));

        // beats offered before grant must not land in the descriptor
        fetch(32'h9000, 3, 1, 1'b1, {32'h91, 32'h92, 32'h93, 32'h94});
        tick();
        check("early_beats_done", 128'({valid, busy}), 128'(0));

        check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        check("total_xfers", 128'(xfers), 128'(6));
        check("total_err_pulses", 128'(errs), 128'(2));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
